// File: rtl/interrupt_controller.sv
// interrupt_controller: prioritised edge-latched interrupt controller with EPC stack; preemption via INTERRUPT_NESTING_EN
module interrupt_controller #(
   parameter int          N_SRC         = 3,
   parameter int          ADDR_BITS     = 32,
   parameter logic [31:0] VECTOR_BASE   = 32'h3020,
   parameter logic [31:0] VECTOR_STRIDE = 32'h0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_SRC-1:0]     irq_in,
   input  logic                 ie,
   input  logic                 stall,
   input  logic                 eret,
   input  logic [ADDR_BITS-1:0] pc_ret,
   output logic                 INT,
   output logic [ADDR_BITS-1:0] int_vec,
   output logic [ADDR_BITS-1:0] EPC_out,
   output logic [N_SRC-1:0]     pending,
   output logic [N_SRC-1:0]     in_service
);
`ifdef INTERRUPT_NESTING_EN
   localparam int STK  = N_SRC;
   localparam bit NEST = 1'b1;
`else
   localparam int STK  = 1;
   localparam bit NEST = 1'b0;
`endif
   localparam int PW = $clog2(N_SRC + 1);
   localparam int DW = $clog2(STK + 1);
   logic [N_SRC-1:0]     irq_prev_q, irq_prev_d, pending_q, pending_d, in_service_q, in_service_d;
   logic [DW-1:0]        depth_q, depth_d;
   logic [ADDR_BITS-1:0] stack_q [STK], stack_d [STK];
   logic [ADDR_BITS-1:0] epc_q, epc_d;
   logic [PW-1:0]        cand_prio, cur_prio, cand_idx, cur_idx;
   logic                 pop;
   always_comb begin
      cand_prio = '0;
      cur_prio  = '0;
      for (int i = 0; i < N_SRC; i++) begin
         cand_prio = pending_q[i] ? PW'(i + 1) : cand_prio;
         cur_prio  = in_service_q[i] ? PW'(i + 1) : cur_prio;
      end
      cand_idx = cand_prio - 1'b1;
      cur_idx  = cur_prio - 1'b1;
   end
   assign INT        = ie & ~stall & ~eret & ~rst & (cand_prio > cur_prio) & (NEST | ~|in_service_q);
   assign int_vec    = ADDR_BITS'(VECTOR_BASE + VECTOR_STRIDE * 32'(cand_idx));
   assign pop        = eret & (depth_q != '0);
   assign EPC_out    = epc_q;
   assign pending    = pending_q;
   assign in_service = in_service_q;
   always_comb begin
      irq_prev_d   = irq_in;
      pending_d    = pending_q;
      in_service_d = in_service_q;
      depth_d      = depth_q;
      stack_d      = stack_q;
      epc_d        = epc_q;
      if (INT) begin
         pending_d[cand_idx]    = 1'b0;
         in_service_d[cand_idx] = 1'b1;
         depth_d                = depth_q + 1'b1;
         epc_d                  = pc_ret;
         for (int s = 0; s < STK; s++)
            if (s == int'(depth_q)) stack_d[s] = pc_ret;
      end else if (pop) begin
         in_service_d[cur_idx] = 1'b0;
         depth_d               = depth_q - 1'b1;
         epc_d                 = '0;
         for (int s = 0; s < STK; s++)
            if (s + 2 == int'(depth_q)) epc_d = stack_q[s];
      end
      pending_d = pending_d | (irq_in & ~irq_prev_q);
   end
   // irq history tracks the lines during reset so a level held through reset is not an edge
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_prev_q   <= irq_in;
         pending_q    <= '0;
         in_service_q <= '0;
         depth_q      <= '0;
         stack_q      <= '{default: '0};
         epc_q        <= '0;
      end else begin
         irq_prev_q   <= irq_prev_d;
         pending_q    <= pending_d;
         in_service_q <= in_service_d;
         depth_q      <= depth_d;
         stack_q      <= stack_d;
         epc_q        <= epc_d;
      end
   end
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: scoreboarded random and directed stimulus against a source-stack reference model
module tb_interrupt_controller;
   localparam logic [31:0] BASE   = 32'h3020;
   localparam logic [31:0] STRIDE = 32'h10;
   logic        clk = 1'b0;
   logic        rst, ie, stall, eret, int_o;
   logic [2:0]  irq_in, pending, in_service;
   logic [31:0] pc_ret, int_vec, epc_out;
   int checks = 0, failures = 0, cyc = 0;
   typedef struct {
      bit          known;
      bit          take;
      logic [31:0] vec;
      logic [2:0]  pend;
      logic [2:0]  svc;
      logic [31:0] epc;
      int          cyc;
   } exp_t;
   exp_t        sb[$];
   bit   [2:0]  m_pend, m_prev;
   int          m_svc[$];
   logic [31:0] m_epc[$];
   bit          m_known = 0;
   bit          done = 0;

   interrupt_controller #(.VECTOR_STRIDE(STRIDE)) dut (
      .clk(clk), .rst(rst), .irq_in(irq_in), .ie(ie), .stall(stall), .eret(eret),
      .pc_ret(pc_ret), .INT(int_o), .int_vec(int_vec), .EPC_out(epc_out),
      .pending(pending), .in_service(in_service)
   );

   always #5 clk = ~clk;

   task automatic drive(input bit r, input logic [2:0] irq, input bit e, input bit s, input bit er, input logic [31:0] pc);
      exp_t x;
      int cand, cur;
      @(negedge clk);
      rst = r; irq_in = irq; ie = e; stall = s; eret = er; pc_ret = pc;
      cyc++;
      cand = -1;
      for (int i = 0; i < 3; i++) if (m_pend[i]) cand = i;
      cur = m_svc.size() > 0 ? m_svc[$] : -1;
      x.known = m_known;
      x.pend  = m_pend;
      x.svc   = '0;
      foreach (m_svc[k]) x.svc[m_svc[k]] = 1'b1;
      x.epc   = m_epc.size() > 0 ? m_epc[$] : 32'h0;
      x.take  = e && !s && !er && !r && cand > cur;
`ifndef INTERRUPT_NESTING_EN
      x.take  = x.take && m_svc.size() == 0;
`endif
      x.vec   = BASE + STRIDE * cand;
      x.cyc   = cyc;
      sb.push_back(x);
      if (r) begin
         m_pend = '0; m_svc.delete(); m_epc.delete(); m_known = 1; m_prev = irq;
      end else begin
         if (x.take) begin
            m_svc.push_back(cand); m_epc.push_back(pc); m_pend[cand] = 1'b0;
         end else if (er && m_svc.size() > 0) begin
            void'(m_svc.pop_back()); void'(m_epc.pop_back());
         end
         m_pend = m_pend | (irq & ~m_prev);
         m_prev = irq;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp, input int c);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", name, c, got, exp);
      end
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("INT", 32'(int_o), 32'(x.take), x.cyc);
            if (x.take) chk("int_vec", int_vec, x.vec, x.cyc);
            if (x.known) begin
               chk("pending", 32'(pending), 32'(x.pend), x.cyc);
               chk("in_service", 32'(in_service), 32'(x.svc), x.cyc);
               chk("EPC_out", epc_out, x.epc, x.cyc);
            end
         end
      end
   end

   initial begin : stim
      drive(1, 3'b111, 1, 0, 0, 32'h0);
      drive(1, 3'b111, 1, 0, 0, 32'h0);
      drive(0, 3'b111, 1, 0, 0, 32'h0);
      drive(0, 3'b000, 1, 0, 0, 32'h0);
      drive(0, 3'b000, 1, 0, 0, 32'h0);
      drive(0, 3'b001, 1, 0, 0, 32'h1000);
      drive(0, 3'b001, 1, 0, 0, 32'h1000);
      drive(0, 3'b001, 1, 0, 0, 32'h1004);
      drive(0, 3'b101, 1, 0, 0, 32'h3040);
      drive(0, 3'b101, 1, 0, 0, 32'h3040);
      drive(0, 3'b101, 1, 0, 0, 32'h3044);
      drive(0, 3'b000, 1, 0, 1, 32'h0);
      drive(0, 3'b000, 1, 0, 0, 32'h0);
      drive(0, 3'b000, 1, 0, 1, 32'h0);
      drive(0, 3'b000, 1, 0, 0, 32'h0);
      drive(0, 3'b000, 1, 0, 1, 32'h0);
      drive(0, 3'b100, 1, 0, 0, 32'h2000);
      drive(0, 3'b100, 1, 0, 0, 32'h2000);
      drive(0, 3'b101, 1, 0, 0, 32'h2004);
      drive(0, 3'b101, 1, 0, 0, 32'h2008);
      drive(0, 3'b000, 1, 0, 1, 32'h0);
      drive(0, 3'b000, 1, 0, 0, 32'h200c);
      drive(0, 3'b000, 1, 0, 1, 32'h0);
      drive(0, 3'b001, 0, 0, 0, 32'h4000);
      drive(0, 3'b000, 0, 0, 0, 32'h4000);
      drive(0, 3'b000, 1, 1, 0, 32'h4000);
      drive(0, 3'b000, 1, 0, 1, 32'h4000);
      drive(0, 3'b000, 1, 0, 0, 32'h4004);
      drive(0, 3'b000, 1, 0, 1, 32'h0);
      drive(0, 3'b011, 1, 0, 0, 32'h5000);
      drive(0, 3'b011, 1, 0, 0, 32'h5000);
      drive(0, 3'b111, 1, 0, 0, 32'h5004);
      drive(0, 3'b111, 1, 0, 0, 32'h5008);
      drive(0, 3'b111, 1, 0, 0, 32'h500c);
      for (int k = 0; k < 5; k++) drive(0, 3'b000, 1, 0, 1, 32'h0);
      for (int n = 0; n < 2000; n++)
         drive($urandom_range(0, 199) == 0, 3'($urandom), $urandom_range(0, 9) != 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0, $urandom);
      drive(0, 3'b000, 1, 0, 0, 32'h0);
      repeat (3) @(negedge clk);
      done = 1;
   end

   initial begin : finish
      fork
         wait (done);
         #300000;
      join_any
      if (!done || sb.size() != 0) begin
         failures++;
         $display("FAIL timeout done=%0d queued=%0d expected done=1 queued=0", done, sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
